// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath with memory wait states,
// illegal-opcode halt and a retired-instruction counter.
module mips_multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic [3:0]       state,
   output logic             halted,
   output logic             retire,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t cur, nxt;
   logic   retire_ev;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur         <= S_FETCH;
         retire      <= 1'b0;
         instr_count <= '0;
      end else begin
         cur    <= nxt;
         retire <= retire_ev;
         if (retire_ev)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   assign state = cur;

   always_comb begin
      nxt         = cur;
      retire_ev   = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      halted      = 1'b0;
      case (cur)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) nxt = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (Opcode)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_R:         nxt = S_EXEC;
               OP_BEQ:       nxt = S_BRANCH;
               OP_J:         nxt = S_JUMP;
               OP_ADDI:      nxt = S_ADDIEX;
               default:      nxt = S_HALT;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            // Opcode is re-sampled here; anything but lw/sw is treated as illegal
            case (Opcode)
               OP_LW:   nxt = S_MEMRD;
               OP_SW:   nxt = S_MEMWR;
               default: nxt = S_HALT;
            endcase
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) nxt = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite  = 1'b1;
            MemtoReg  = 1'b1;
            nxt       = S_FETCH;
            retire_ev = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               nxt       = S_FETCH;
               retire_ev = 1'b1;
            end
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            nxt     = S_RWB;
         end
         S_RWB: begin
            RegWrite  = 1'b1;
            RegDst    = 1'b1;
            nxt       = S_FETCH;
            retire_ev = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            nxt         = S_FETCH;
            retire_ev   = 1'b1;
         end
         S_JUMP: begin
            PCWrite   = 1'b1;
            PCSource  = 2'b10;
            nxt       = S_FETCH;
            retire_ev = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            nxt     = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite  = 1'b1;
            nxt       = S_FETCH;
            retire_ev = 1'b1;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: nxt = S_HALT;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized instruction-stream bench for mips_multicycle_control; each instruction is
// expanded into its expected state walk and checked cycle by cycle.
module tb_mips_multicycle_control;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    Opcode;
   logic          mem_ready;
   logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic          MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0]    ALUSrcB, ALUOp, PCSource;
   logic [3:0]    state;
   logic          halted, retire;
   logic [CW-1:0] instr_count;

   mips_multicycle_control #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .state(state), .halted(halted), .retire(retire), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   logic [16:0] obs_ctrl;
   assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted};

   int            compared   = 0;
   int            mismatched = 0;
   logic          exp_ret;
   logic [CW-1:0] exp_cnt;

   // Control word each step of the instruction walk must present
   function automatic logic [16:0] exp_ctrl(input int s, input logic mr);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, hlt;
      logic [1:0] asb, aop, psrc;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, hlt} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (s)
         0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
         9:  begin pcw = 1; psrc = 2'b10; end
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
         12: hlt = 1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, hlt};
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom_range(0, 63));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Entered at posedge+1; drives inputs, checks, then advances one cycle
   task automatic step(input int exp_st, input logic mr, input logic [5:0] op, input logic last);
      mem_ready = mr;
      Opcode    = op;
      #1;
      chk("state",  32'(state),       32'(exp_st));
      chk("ctrl",   32'(obs_ctrl),    32'(exp_ctrl(exp_st, mr)));
      chk("retire", 32'(retire),      32'(exp_ret));
      chk("count",  32'(instr_count), 32'(exp_cnt));
      @(posedge clk);
      #1;
      exp_ret = last;
      if (last) exp_cnt = exp_cnt + 1'b1;
   endtask

   task automatic do_reset(input int exp_cur);
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("pre_reset_state", 32'(state), 32'(exp_cur));
      @(posedge clk);
      #1;
      reset   = 1'b0;
      exp_ret = 1'b0;
      exp_cnt = '0;
   endtask

   localparam logic [5:0] OPS [6] = '{6'b000000, 6'b100011, 6'b101011,
                                      6'b000100, 6'b000010, 6'b001000};

   // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 addi
   task automatic run_instr(input int kind, input int fw, input int mw);
      logic [5:0] op;
      op = OPS[kind];
      for (int i = 0; i < fw; i++) step(0, 1'b0, rop(), 1'b0);
      step(0, 1'b1, rop(), 1'b0);
      step(1, 1'($urandom_range(0, 1)), op, 1'b0);
      case (kind)
         0: begin
            step(6, 1'($urandom_range(0, 1)), rop(), 1'b0);
            step(7, 1'($urandom_range(0, 1)), rop(), 1'b1);
         end
         1: begin
            step(2, 1'($urandom_range(0, 1)), op, 1'b0);
            for (int i = 0; i < mw; i++) step(3, 1'b0, rop(), 1'b0);
            step(3, 1'b1, rop(), 1'b0);
            step(4, 1'($urandom_range(0, 1)), rop(), 1'b1);
         end
         2: begin
            step(2, 1'($urandom_range(0, 1)), op, 1'b0);
            for (int i = 0; i < mw; i++) step(5, 1'b0, rop(), 1'b0);
            step(5, 1'b1, rop(), 1'b1);
         end
         3: step(8, 1'($urandom_range(0, 1)), rop(), 1'b1);
         4: step(9, 1'($urandom_range(0, 1)), rop(), 1'b1);
         default: begin
            step(10, 1'($urandom_range(0, 1)), rop(), 1'b0);
            step(11, 1'($urandom_range(0, 1)), rop(), 1'b1);
         end
      endcase
   endtask

   initial begin
      logic [CW-1:0] c0;
      reset     = 1'b1;
      mem_ready = 1'b1;
      Opcode    = 6'd0;
      exp_ret   = 1'b0;
      exp_cnt   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state",  32'(state),       32'd0);
      chk("reset_ctrl",   32'(obs_ctrl),    32'(exp_ctrl(0, 1'b1)));
      chk("reset_count",  32'(instr_count), 32'd0);
      chk("reset_halted", 32'(halted),      32'd0);
      reset = 1'b0;

      run_instr(0, 0, 0);                 // R-type
      chk("count_after_r", 32'(instr_count), 32'd1);
      run_instr(1, 3, 2);                 // lw with wait states
      run_instr(3, 0, 0);                 // beq then j
      run_instr(4, 0, 0);

      // Illegal opcode freezes the FSM until reset
      step(0, 1'b1, rop(), 1'b0);
      step(1, 1'b1, 6'b111111, 1'b0);
      for (int i = 0; i < 10; i++) step(12, 1'($urandom_range(0, 1)), rop(), 1'b0);
      do_reset(12);
      step(0, 1'b1, rop(), 1'b0);
      step(1, 1'b1, 6'b000000, 1'b0);
      step(6, 1'b1, rop(), 1'b0);
      step(7, 1'b1, rop(), 1'b1);

      // 16 addi wrap the 4-bit counter back to its starting value
      c0 = exp_cnt;
      for (int i = 0; i < 16; i++) run_instr(5, 0, 0);
      chk("wrap16", 32'(instr_count), 32'(c0));

      // Reset mid-instruction while in ADDIEX
      step(0, 1'b1, rop(), 1'b0);
      step(1, 1'b1, 6'b001000, 1'b0);
      do_reset(10);

      for (int n = 0; n < 60; n++)
         run_instr($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3));
      step(0, 1'b1, rop(), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
